fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter counter_width, default 32, SHALL set the PC/address width.
REQ-002 Parameter word_width, default 32, SHALL set the instruction width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 PCF  in  counter_width  SHALL be the current PC from the fetch stage.
REQ-006 PCSrcE  in  1  SHALL signal a taken redirect from execute.
REQ-007 stallD  in  1  SHALL mean decode cannot accept an instruction this cycle.
REQ-008 imem_ready  in  1  SHALL be the instruction-memory request grant.
REQ-009 imem_rvalid  in  1  SHALL mark a valid read response.
REQ-010 imem_rdata  in  word_width  SHALL carry the response data.
REQ-011 imem_req  out  1  SHALL be the memory request strobe.
REQ-012 imem_addr  out  counter_width  SHALL be the request address.
REQ-013 stallF_N  out  1  SHALL drive the fetch PC hold control: 0 advances the PC, 1 holds it.
REQ-014 instrF  out  word_width  SHALL be the instruction delivered to decode.
REQ-015 instrF_valid  out  1  SHALL qualify instrF.
REQ-016 flushD  out  1  SHALL flush the decode register.
REQ-017 stall_cycles  out  32  SHALL count cycles with stallF_N=1.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and DROP.
REQ-019 IDLE SHALL move to REQ unconditionally on the next cycle.
REQ-020 In REQ, imem_req=1 and imem_addr=PCF; imem_ready=1 SHALL move to WAIT; otherwise the FSM stays in REQ with imem_addr tracking PCF.
REQ-021 The earliest imem_rvalid accepted SHALL be the cycle after the grant; imem_rvalid in any other state except DROP SHALL be ignored.
REQ-022 In WAIT with imem_rvalid=1, stallD=0 and PCSrcE=0: instrF=imem_rdata, instrF_valid=1 and stallF_N=0 SHALL hold combinationally, and the next state SHALL be REQ.
REQ-023 In WAIT with imem_rvalid=1, stallD=1 and PCSrcE=0: imem_rdata SHALL be captured in a hold register and the next state SHALL be HOLD.
REQ-024 In HOLD, instrF SHALL be the hold register with instrF_valid=1; stallD=0 and PCSrcE=0 SHALL give stallF_N=0 and move to REQ.
REQ-025 stallF_N SHALL be 0 only in the delivery cycles of REQ-022 and REQ-024, and 1 in every other cycle.
REQ-026 PCSrcE=1 in any state SHALL assert flushD the same cycle, force instrF_valid=0 and suppress the stallF_N=0 pulse.
REQ-027 PCSrcE=1 in WAIT without imem_rvalid SHALL move to DROP; with imem_rvalid SHALL discard the data and move to REQ.
REQ-028 PCSrcE=1 in HOLD SHALL discard the hold register and move to REQ.
REQ-029 PCSrcE=1 in REQ or IDLE SHALL stay in or enter REQ; a grant in that same cycle SHALL still move to WAIT.
REQ-030 DROP SHALL discard the next imem_rvalid response and then move to REQ, with imem_req=0 while in DROP.
REQ-031 When instrF_valid=0, instrF SHALL equal the NOP 32'h00000013.
REQ-032 stall_cycles SHALL increment by 1 each cycle stallF_N=1 and saturate at 32'hFFFFFFFF.

Reset
REQ-033 reset=1 SHALL immediately force state IDLE, imem_req=0, stallF_N=1, instrF_valid=0, flushD=0, hold register=NOP and stall_cycles=0.
REQ-034 Reset asserted mid-transaction SHALL abandon any outstanding response; a response after deassertion SHALL be ignored unless the FSM is in WAIT.

Structure
REQ-035 The state enum, the NOP constant and the counter width SHALL live in a shared package fetch_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the hold register and counter SHALL be inline.

Verification
REQ-037 Reset release, imem_ready=1, 1-cycle latency, stallD=0 -> first stallF_N=0 pulse in cycle 3 after reset, with instrF equal to rdata.
REQ-038 rvalid with stallD=1 for 3 cycles, rdata=32'hDEADBEEF -> HOLD with instrF=32'hDEADBEEF valid for 3 cycles, and stallF_N pulses once when stallD falls.
REQ-039 PCSrcE in WAIT, then rvalid next cycle -> flushD=1 in the PCSrcE cycle, the response dropped, no stallF_N pulse, and REQ resumes after the dropped response.
REQ-040 PCSrcE coincident with rvalid -> data discarded, instrF=NOP, next state REQ.
REQ-041 Forced stallF_N=1 for 2^32+5 cycles (counter preloaded near max) -> stall_cycles saturates at 32'hFFFFFFFF.
REQ-042 Reset asserted during WAIT -> all outputs reach their reset values asynchronously, and a late rvalid after release is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The NOP word is what decode sees whenever no instruction is being delivered.
package fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_DROP
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam int          STALL_CNT_W = 32;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues one memory request at a time, buffers the
// response while decode is stalled, and drops responses made stale by a redirect.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int counter_width = 32,
   parameter int word_width    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [counter_width-1:0] PCF,
   input  logic                     PCSrcE,
   input  logic                     stallD,
   input  logic                     imem_ready,
   input  logic                     imem_rvalid,
   input  logic [word_width-1:0]    imem_rdata,
   output logic                     imem_req,
   output logic [counter_width-1:0] imem_addr,
   output logic                     stallF_N,
   output logic [word_width-1:0]    instrF,
   output logic                     instrF_valid,
   output logic                     flushD,
   output logic [STALL_CNT_W-1:0]   stall_cycles
);

   localparam logic [word_width-1:0] NOP_WORD = word_width'(NOP_INSTR);

   fetch_state_t                state_reg, state_next;
   logic [word_width-1:0]       hold_reg, hold_next;
   logic [STALL_CNT_W-1:0]      stall_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         hold_reg  <= NOP_WORD;
      end else begin
         state_reg <= state_next;
         hold_reg  <= hold_next;
      end
   end

   // The address simply follows the PC; it only matters while imem_req is high.
   assign imem_addr = PCF;

   always_comb begin
      state_next   = state_reg;
      hold_next    = hold_reg;
      imem_req     = 1'b0;
      stallF_N     = 1'b1;
      instrF       = NOP_WORD;
      instrF_valid = 1'b0;
      // Reset is asynchronous, so the flush must not leak through while it is held.
      flushD       = PCSrcE & ~reset;

      case (state_reg)
         ST_IDLE: begin
            state_next = ST_REQ;
         end
         ST_REQ: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (PCSrcE) begin
               state_next = imem_rvalid ? ST_REQ : ST_DROP;
            end else if (imem_rvalid) begin
               if (stallD) begin
                  hold_next  = imem_rdata;
                  state_next = ST_HOLD;
               end else begin
                  instrF       = imem_rdata;
                  instrF_valid = 1'b1;
                  stallF_N     = 1'b0;
                  state_next   = ST_REQ;
               end
            end
         end
         ST_HOLD: begin
            if (PCSrcE) begin
               hold_next  = NOP_WORD;
               state_next = ST_REQ;
            end else begin
               instrF       = hold_reg;
               instrF_valid = 1'b1;
               if (!stallD) begin
                  stallF_N   = 1'b0;
                  hold_next  = NOP_WORD;
                  state_next = ST_REQ;
               end
            end
         end
         ST_DROP: begin
            if (imem_rvalid) begin
               state_next = ST_REQ;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_reg <= '0;
      end else if (stallF_N && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   assign stall_cycles = stall_cnt_reg;

endmodule
